// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled with its own tick divider, mid-bit sampling,
// valid/ack handshake with sticky overrun and one-clock framing-error pulse.
module uart_rx #(
  parameter int freq     = 50000000,
  parameter int baudrate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Serial_in,
  input  logic       rx_ack,
  output logic [7:0] RX_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int DIV = freq / (baudrate * 16);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          sync_1;
  logic          rxs;
  logic [3:0]    s;
  logic [2:0]    n;
  logic [7:0]    b;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sync_1  <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sync_1  <= Serial_in;
      rxs     <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      RX_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // Ack is applied first so a completing byte in the same cycle overrides it.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state   <= START;
              s       <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (s == 4'd7) begin
              if (!rxs) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
          DATA: begin
            if (s == 4'd15) begin
              b <= {rxs, b[7:1]};
              s <= '0;
              if (n == 3'd7) state <= STOP;
              else           n     <= n + 3'd1;
            end else begin
              s <= s + 4'd1;
            end
          end
          STOP: begin
            if (s == 4'd15) begin
              if (rxs) begin
                RX_data  <= b;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) overrun <= 1'b1;
                state    <= IDLE;
                rx_busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
          WAIT_HIGH: begin
            // A line held low must go high before a new start can be detected.
            if (rxs) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected outcomes per frame,
// a monitor pops and compares each time the receiver drops rx_busy.
module tb_uart_rx;
  localparam int FREQ    = 64;
  localparam int BAUD    = 1;
  localparam int BIT     = FREQ / BAUD;
  localparam int BIT_DEF = 50000000 / 9600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Serial_in, rx_ack;
  logic [7:0] RX_data;
  logic       rx_valid, overrun, frame_err, rx_busy;

  logic       reset_def, serial_def, ack_def;
  logic [7:0] data_def;
  logic       valid_def, ovr_def, ferr_def, busy_def;

  uart_rx #(.freq(FREQ), .baudrate(BAUD)) dut (
    .clk(clk), .reset(reset), .Serial_in(Serial_in), .rx_ack(rx_ack),
    .RX_data(RX_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx dut_def (
    .clk(clk), .reset(reset_def), .Serial_in(serial_def), .rx_ack(ack_def),
    .RX_data(data_def), .rx_valid(valid_def), .overrun(ovr_def),
    .frame_err(ferr_def), .rx_busy(busy_def)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ovr;
    int         ferr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_data;
  logic       m_valid, m_ovr;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of each receive event from the handshake rules.
  task automatic expect_good(input logic [7:0] d, input logic ack_same);
    exp_t e;
    e.data  = d;
    e.valid = 1'b1;
    e.ovr   = ack_same ? 1'b0 : (m_valid | m_ovr);
    e.ferr  = 0;
    m_data  = e.data;
    m_valid = e.valid;
    m_ovr   = e.ovr;
    sb.push_back(e);
  endtask

  task automatic expect_no_byte(input int ferr);
    exp_t e;
    e.data  = m_data;
    e.valid = m_valid;
    e.ovr   = m_ovr;
    e.ferr  = ferr;
    sb.push_back(e);
  endtask

  task automatic line(input logic v, input int clocks);
    Serial_in = v;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low_bits);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    if (stop_low_bits == 0) line(1'b1, BIT);
    else                    line(1'b0, stop_low_bits * BIT);
  endtask

  task automatic do_ack();
    chk("valid_before_ack", {31'd0, rx_valid}, {31'd0, m_valid});
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    chk("valid_after_ack", {31'd0, rx_valid}, {31'd0, m_valid});
    chk("overrun_after_ack", {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  // Stop sample lands 152 ticks (of 4 clocks) after the detection edge,
  // which is the edge at which rx_busy rises.
  task automatic ack_on_completion();
    int w;
    w = 0;
    while (!rx_busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!rx_busy) begin
      chk("busy_rise_timeout", 32'd0, 32'd1);
    end else begin
      repeat (152 * 4 - 1) @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
    end
  endtask

  initial begin : monitor
    logic prev_busy;
    int   ferr_cnt;
    exp_t e;
    prev_busy = 1'b0;
    ferr_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_busy = 1'b0;
        ferr_cnt  = 0;
      end else begin
        if (frame_err) ferr_cnt++;
        if (prev_busy && !rx_busy) begin
          done_cnt++;
          $display("event %0d: RX_data=%02h rx_valid=%0b overrun=%0b frame_err_pulses=%0d",
                   done_cnt, RX_data, rx_valid, overrun, ferr_cnt);
          if (sb.size() == 0) begin
            chk("unexpected_event", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("RX_data", {24'd0, RX_data}, {24'd0, e.data});
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, e.valid});
            chk("overrun", {31'd0, overrun}, {31'd0, e.ovr});
            chk("frame_err_pulses", ferr_cnt, e.ferr);
          end
          ferr_cnt = 0;
        end
        prev_busy = rx_busy;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_RX_data"}, {24'd0, RX_data}, 32'd0);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_rx_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic random_tests();
    int         kind, gap;
    logic [7:0] d;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      d    = 8'($urandom);
      if (kind == 0) begin
        expect_no_byte(0);
        line(1'b0, $urandom_range(5, 24));
        line(1'b1, 64);
      end else if (kind == 1) begin
        expect_no_byte(1);
        send_frame(d, $urandom_range(1, 3));
        line(1'b1, 24);
      end else begin
        expect_good(d, 1'b0);
        send_frame(d, 0);
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 80);
      if (gap > 0) begin
        line(1'b1, gap);
        if ($urandom_range(0, 1) == 1) do_ack();
      end
    end
    line(1'b1, 64);
  endtask

  task automatic fast_tests();
    reset = 1'b1; Serial_in = 1'b1; rx_ack = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    line(1'b1, 8);
    do_ack();

    expect_good(8'hA5, 1'b0); send_frame(8'hA5, 0); line(1'b1, 64);
    do_ack();

    expect_no_byte(0); line(1'b0, 20); line(1'b1, 64);

    expect_no_byte(1); send_frame(8'h3C, 3);
    chk("busy_while_held_low", {31'd0, rx_busy}, 32'd1);
    line(1'b1, 32);
    expect_good(8'h55, 1'b0); send_frame(8'h55, 0); line(1'b1, 64);
    do_ack();

    expect_good(8'h11, 1'b0); send_frame(8'h11, 0);
    expect_good(8'h22, 1'b0); send_frame(8'h22, 0); line(1'b1, 64);
    do_ack();

    expect_good(8'h11, 1'b0); send_frame(8'h11, 0);
    expect_good(8'h22, 1'b1);
    fork
      send_frame(8'h22, 0);
      ack_on_completion();
    join
    line(1'b1, 64);
    do_ack();

    expect_good(8'h40, 1'b0); send_frame(8'h40, 0); line(1'b1, 32);
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(1'b1, BIT);
    reset = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    Serial_in = 1'b1; m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    line(1'b1, 16);
    expect_good(8'h81, 1'b0); send_frame(8'h81, 0); line(1'b1, 64);
    do_ack();

    random_tests();
  endtask

  task automatic default_test();
    logic [7:0] d;
    d = 8'hA5;
    reset_def = 1'b1; serial_def = 1'b1; ack_def = 1'b0;
    repeat (3) @(negedge clk);
    reset_def = 1'b0;
    repeat (10) @(negedge clk);
    serial_def = 1'b0;
    repeat (BIT_DEF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_def = d[i];
      repeat (BIT_DEF) @(negedge clk);
    end
    serial_def = 1'b1;
    repeat (BIT_DEF) @(negedge clk);
    $display("default-rate frame: RX_data=%02h rx_valid=%0b overrun=%0b rx_busy=%0b",
             data_def, valid_def, ovr_def, busy_def);
    chk("def_RX_data", {24'd0, data_def}, 32'hA5);
    chk("def_rx_valid", {31'd0, valid_def}, 32'd1);
    chk("def_overrun", {31'd0, ovr_def}, 32'd0);
    chk("def_rx_busy", {31'd0, busy_def}, 32'd0);
    ack_def = 1'b1;
    @(negedge clk);
    ack_def = 1'b0;
    chk("def_valid_after_ack", {31'd0, valid_def}, 32'd0);
  endtask

  initial begin
    fork
      fast_tests();
      default_test();
    join
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
